// File: rtl/chdr_deframer_pkg.sv
// Shared constants, header layout and FSM state type for the CHDR data deframer.
// Also holds the packed header view used by the header decoder.
package chdr_deframer_pkg;

  localparam logic [2:0] PKT_TYPE_DATA    = 3'd6;
  localparam logic [2:0] PKT_TYPE_DATA_TS = 3'd7;

  localparam int HDR_EOB_BIT    = 57;
  localparam int HDR_TYPE_LSB   = 53;
  localparam int HDR_NMDATA_LSB = 48;
  localparam int HDR_SEQ_LSB    = 32;
  localparam int HDR_LEN_LSB    = 16;

  typedef enum logic [2:0] {
    ST_HDR     = 3'd0,
    ST_TS      = 3'd1,
    ST_MDATA   = 3'd2,
    ST_PYLD_LO = 3'd3,
    ST_PYLD_HI = 3'd4,
    ST_DROP    = 3'd5
  } state_t;

  typedef struct packed {
    logic        eob;
    logic [2:0]  pkt_type;
    logic [4:0]  num_mdata;
    logic [15:0] seqnum;
    logic [15:0] length;
  } chdr_hdr_t;

endpackage

// File: rtl/chdr_hdr_decode.sv
// Combinational CHDR header unpack with payload byte count P and item count N.
// P = Length - 8 - 8*has_ts - 8*NumMData; N = P >> 2.
module chdr_hdr_decode
  import chdr_deframer_pkg::*;
(
  input  logic [63:0] hdr_i,
  output logic        eob_o,
  output logic [15:0] seqnum_o,
  output logic [4:0]  num_mdata_o,
  output logic        has_ts_o,
  output logic        type_ok_o,
  output logic        p_neg_o,
  output logic        p_resid_o,
  output logic        n_zero_o,
  output logic [13:0] n_items_o
);

  chdr_hdr_t          hdr;
  logic signed [17:0] p_bytes;
  logic               unused_bits;

  assign hdr.eob       = hdr_i[HDR_EOB_BIT];
  assign hdr.pkt_type  = hdr_i[HDR_TYPE_LSB +: 3];
  assign hdr.num_mdata = hdr_i[HDR_NMDATA_LSB +: 5];
  assign hdr.seqnum    = hdr_i[HDR_SEQ_LSB +: 16];
  assign hdr.length    = hdr_i[HDR_LEN_LSB +: 16];

  assign eob_o       = hdr.eob;
  assign seqnum_o    = hdr.seqnum;
  assign num_mdata_o = hdr.num_mdata;
  assign has_ts_o    = (hdr.pkt_type == PKT_TYPE_DATA_TS);
  assign type_ok_o   = (hdr.pkt_type == PKT_TYPE_DATA) || has_ts_o;

  // 18-bit signed math so that short Length values go negative instead of wrapping
  always_comb begin
    p_bytes = $signed({2'b00, hdr.length}) - 18'sd8
            - (has_ts_o ? 18'sd8 : 18'sd0)
            - $signed({10'd0, hdr.num_mdata, 3'b000});
  end

  assign p_neg_o   = p_bytes[17];
  assign p_resid_o = !p_neg_o && (p_bytes[1:0] != 2'b00);
  assign n_items_o = p_neg_o ? 14'd0 : p_bytes[15:2];
  assign n_zero_o  = (n_items_o == 14'd0);

  assign unused_bits = ^{hdr_i[63:58], hdr_i[56], hdr_i[15:0], p_bytes[16]};

endmodule

// File: rtl/chdr_data_deframer.sv
// CHDR (64-bit) to 32-bit item deframer with per-packet sideband registers.
// Define CHDR_DEFRAMER_ERR_CNT_EN to build the drop / length-error counters.
//
// Handshake: a transfer happens on any edge where tvalid && tready; tvalid never
// depends on tready, and data/last are held while tvalid && !tready. The item
// path is combinational: m_item_tvalid follows s_chdr_tvalid in the payload states.
module chdr_data_deframer
  import chdr_deframer_pkg::*;
#(
  parameter int CHDR_W = 64,
  parameter int ITEM_W = 32,
  parameter int MTU    = 10
) (
  input  logic              rfnoc_chdr_clk,
  input  logic              rfnoc_chdr_rst,
  input  logic [CHDR_W-1:0] s_chdr_tdata,
  input  logic              s_chdr_tlast,
  input  logic              s_chdr_tvalid,
  output logic              s_chdr_tready,
  output logic [ITEM_W-1:0] m_item_tdata,
  output logic              m_item_tlast,
  output logic              m_item_tvalid,
  input  logic              m_item_tready,
  output logic              m_pkt_eob,
  output logic              m_pkt_has_ts,
  output logic [63:0]       m_pkt_ts,
  output logic [15:0]       m_pkt_seqnum,
  output logic [15:0]       cnt_drop,
  output logic [15:0]       cnt_len_err,
  output state_t            dbg_state
);

  localparam int CW = MTU + 1;

  if (CHDR_W != 64) begin : g_bad_chdr_w
    $error("chdr_data_deframer: only CHDR_W = 64 is supported");
  end
  if (ITEM_W != 32) begin : g_bad_item_w
    $error("chdr_data_deframer: only ITEM_W = 32 is supported");
  end

  state_t          state_q;
  logic [CW-1:0]   items_left_q;
  logic [4:0]      mdata_left_q;
  logic            drop_err_q;
  logic            eob_q;
  logic            has_ts_q;
  logic [63:0]     ts_q;
  logic [15:0]     seqnum_q;

  logic            dec_eob;
  logic [15:0]     dec_seqnum;
  logic [4:0]      dec_num_mdata;
  logic            dec_has_ts;
  logic            dec_type_ok;
  logic            dec_p_neg;
  logic            dec_p_resid;
  logic            dec_n_zero;
  logic [13:0]     dec_n_items;

  logic            s_acc;
  logic            item_acc;
  logic            last_item;
  logic            drop_inc;
  logic            len_err_inc;

  chdr_hdr_decode u_hdr_decode (
    .hdr_i       (s_chdr_tdata[63:0]),
    .eob_o       (dec_eob),
    .seqnum_o    (dec_seqnum),
    .num_mdata_o (dec_num_mdata),
    .has_ts_o    (dec_has_ts),
    .type_ok_o   (dec_type_ok),
    .p_neg_o     (dec_p_neg),
    .p_resid_o   (dec_p_resid),
    .n_zero_o    (dec_n_zero),
    .n_items_o   (dec_n_items)
  );

  assign last_item = (items_left_q == CW'(1));

  always_comb begin
    s_chdr_tready = 1'b0;
    m_item_tvalid = 1'b0;
    m_item_tdata  = '0;
    m_item_tlast  = 1'b0;
    if (!rfnoc_chdr_rst) begin
      case (state_q)
        // The word is only consumed on its LO item when that item ends the packet
        ST_PYLD_LO: begin
          s_chdr_tready = m_item_tready && last_item;
          m_item_tvalid = s_chdr_tvalid;
          m_item_tdata  = s_chdr_tdata[31:0];
          m_item_tlast  = last_item;
        end
        ST_PYLD_HI: begin
          s_chdr_tready = m_item_tready;
          m_item_tvalid = s_chdr_tvalid;
          m_item_tdata  = s_chdr_tdata[63:32];
          m_item_tlast  = last_item || s_chdr_tlast;
        end
        default: s_chdr_tready = 1'b1;
      endcase
    end
  end

  assign s_acc    = s_chdr_tvalid && s_chdr_tready;
  assign item_acc = m_item_tvalid && m_item_tready;

  always_comb begin
    drop_inc    = 1'b0;
    len_err_inc = 1'b0;
    case (state_q)
      ST_HDR: begin
        drop_inc    = s_acc && !dec_type_ok;
        len_err_inc = s_acc && dec_type_ok &&
                      (dec_p_neg || dec_p_resid || (s_chdr_tlast && !dec_n_zero));
      end
      ST_TS, ST_MDATA: len_err_inc = s_acc && s_chdr_tlast;
      ST_PYLD_HI:      len_err_inc = s_acc && s_chdr_tlast && !last_item;
      ST_DROP:         len_err_inc = s_acc && drop_err_q;
      default: ;
    endcase
  end

  always_ff @(posedge rfnoc_chdr_clk) begin
    if (rfnoc_chdr_rst) begin
      state_q      <= ST_HDR;
      items_left_q <= '0;
      mdata_left_q <= '0;
      drop_err_q   <= 1'b0;
      eob_q        <= 1'b0;
      has_ts_q     <= 1'b0;
      ts_q         <= '0;
      seqnum_q     <= '0;
    end else begin
      case (state_q)
        ST_HDR: if (s_acc) begin
          eob_q        <= dec_eob;
          has_ts_q     <= dec_has_ts;
          ts_q         <= '0;
          seqnum_q     <= dec_seqnum;
          items_left_q <= CW'(dec_n_items);
          mdata_left_q <= dec_num_mdata;
          drop_err_q   <= 1'b0;
          if (s_chdr_tlast)                                 state_q <= ST_HDR;
          else if (!dec_type_ok || dec_p_neg || dec_n_zero) state_q <= ST_DROP;
          else if (dec_has_ts)                              state_q <= ST_TS;
          else if (dec_num_mdata != 5'd0)                   state_q <= ST_MDATA;
          else                                              state_q <= ST_PYLD_LO;
        end
        ST_TS: if (s_acc) begin
          ts_q <= s_chdr_tdata[63:0];
          if (s_chdr_tlast)               state_q <= ST_HDR;
          else if (mdata_left_q != 5'd0)  state_q <= ST_MDATA;
          else                            state_q <= ST_PYLD_LO;
        end
        ST_MDATA: if (s_acc) begin
          mdata_left_q <= mdata_left_q - 5'd1;
          if (s_chdr_tlast)               state_q <= ST_HDR;
          else if (mdata_left_q == 5'd1)  state_q <= ST_PYLD_LO;
        end
        ST_PYLD_LO: if (item_acc) begin
          if (last_item) begin
            state_q    <= s_chdr_tlast ? ST_HDR : ST_DROP;
            drop_err_q <= !s_chdr_tlast;
          end else begin
            items_left_q <= items_left_q - CW'(1);
            state_q      <= ST_PYLD_HI;
          end
        end
        ST_PYLD_HI: if (item_acc) begin
          if (last_item) begin
            state_q    <= s_chdr_tlast ? ST_HDR : ST_DROP;
            drop_err_q <= !s_chdr_tlast;
          end else begin
            items_left_q <= items_left_q - CW'(1);
            state_q      <= s_chdr_tlast ? ST_HDR : ST_PYLD_LO;
          end
        end
        ST_DROP: if (s_acc) begin
          drop_err_q <= 1'b0;
          if (s_chdr_tlast) state_q <= ST_HDR;
        end
        default: state_q <= ST_HDR;
      endcase
    end
  end

  assign m_pkt_eob    = eob_q;
  assign m_pkt_has_ts = has_ts_q;
  assign m_pkt_ts     = ts_q;
  assign m_pkt_seqnum = seqnum_q;
  assign dbg_state    = state_q;

`ifdef CHDR_DEFRAMER_ERR_CNT_EN
  logic [15:0] cnt_drop_q;
  logic [15:0] cnt_len_err_q;

  always_ff @(posedge rfnoc_chdr_clk) begin
    if (rfnoc_chdr_rst) begin
      cnt_drop_q    <= '0;
      cnt_len_err_q <= '0;
    end else begin
      if (drop_inc && (cnt_drop_q != 16'hFFFF))       cnt_drop_q    <= cnt_drop_q + 16'd1;
      if (len_err_inc && (cnt_len_err_q != 16'hFFFF)) cnt_len_err_q <= cnt_len_err_q + 16'd1;
    end
  end

  assign cnt_drop    = cnt_drop_q;
  assign cnt_len_err = cnt_len_err_q;
`else
  logic unused_cnt_inc;
  assign unused_cnt_inc = drop_inc | len_err_inc;
  assign cnt_drop       = '0;
  assign cnt_len_err    = '0;
`endif

endmodule

// File: tb/tb_chdr_data_deframer.sv
// Bench for chdr_data_deframer: table of packet shapes, hand-written corner
// sequences, random stalled traffic against a packet-level model, and reset mid-payload.
module tb_chdr_data_deframer;
  import chdr_deframer_pkg::*;

  localparam int EXP_W = 115; // {tlast, eob, has_ts, seqnum[16], ts[64], item[32]}
`ifdef CHDR_DEFRAMER_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [63:0] s_chdr_tdata;
  logic        s_chdr_tlast;
  logic        s_chdr_tvalid;
  logic        s_chdr_tready;
  logic [31:0] m_item_tdata;
  logic        m_item_tlast;
  logic        m_item_tvalid;
  logic        m_item_tready;
  logic        m_pkt_eob;
  logic        m_pkt_has_ts;
  logic [63:0] m_pkt_ts;
  logic [15:0] m_pkt_seqnum;
  logic [15:0] cnt_drop;
  logic [15:0] cnt_len_err;
  state_t      dbg_state;

  int tests = 0;
  int fails = 0;
  int rx_count = 0;
  int exp_drop = 0;
  int exp_len = 0;
  bit stall_en = 1'b0;
  logic [EXP_W-1:0] exp_q[$];

  typedef struct {
    logic [2:0]  ptype;
    logic        eob;
    logic [4:0]  nmd;
    logic [15:0] len;
    int          words;
    logic [63:0] ts;
    int          exp_items;
    int          exp_drop;
    int          exp_len;
  } vec_t;
  vec_t vecs[12];

  chdr_data_deframer #(.CHDR_W(64), .ITEM_W(32), .MTU(10)) dut (
    .rfnoc_chdr_clk (clk),
    .rfnoc_chdr_rst (rst),
    .s_chdr_tdata   (s_chdr_tdata),
    .s_chdr_tlast   (s_chdr_tlast),
    .s_chdr_tvalid  (s_chdr_tvalid),
    .s_chdr_tready  (s_chdr_tready),
    .m_item_tdata   (m_item_tdata),
    .m_item_tlast   (m_item_tlast),
    .m_item_tvalid  (m_item_tvalid),
    .m_item_tready  (m_item_tready),
    .m_pkt_eob      (m_pkt_eob),
    .m_pkt_has_ts   (m_pkt_has_ts),
    .m_pkt_ts       (m_pkt_ts),
    .m_pkt_seqnum   (m_pkt_seqnum),
    .cnt_drop       (cnt_drop),
    .cnt_len_err    (cnt_len_err),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  initial begin
    m_item_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m_item_tready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_cnt_drop"}, 64'(cnt_drop), CNT_EN ? 64'(exp_drop) : 64'd0);
    check({tag, "_cnt_len_err"}, 64'(cnt_len_err), CNT_EN ? 64'(exp_len) : 64'd0);
  endtask

  task automatic send_word(input logic [63:0] d, input logic l);
    int n;
    if (stall_en) begin
      while ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    s_chdr_tdata  = d;
    s_chdr_tlast  = l;
    s_chdr_tvalid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!s_chdr_tready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      tests++;
      fails++;
      $display("FAIL send_timeout actual=stuck expected=tready");
    end
    @(posedge clk);
    #1;
    s_chdr_tvalid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
  endtask

  function automatic logic [63:0] hdr_word(input logic [2:0] ptype, input logic eob,
                                           input logic [4:0] nmd, input logic [15:0] seq,
                                           input logic [15:0] len);
    return {6'd0, eob, 1'b0, ptype, nmd, seq, len, 16'h0000};
  endfunction

  // Packet-level reference: derive the expected items and counter increments
  // directly from the header rules, then drive the words.
  task automatic run_pkt(input logic [2:0] ptype, input logic eob, input logic [4:0] nmd,
                         input logic [15:0] len, input int tot_words, input logic [63:0] ts,
                         output int n_rx, output int d_drop, output int d_len);
    logic [63:0] words[$];
    logic [63:0] w;
    logic [63:0] ts_exp;
    logic [31:0] item;
    logic [15:0] seq;
    int h, p, n, first, avail, emit, rx0;
    seq = 16'($urandom);
    words.push_back(hdr_word(ptype, eob, nmd, seq, len));
    for (int i = 1; i < tot_words; i++)
      words.push_back((i == 1 && ptype == 3'd7) ? ts : {$urandom, $urandom});
    d_drop = 0;
    d_len  = 0;
    if (ptype != 3'd6 && ptype != 3'd7) begin
      d_drop = 1;
    end else begin
      h = (ptype == 3'd7) ? 1 : 0;
      p = int'(len) - 8 - 8 * h - 8 * int'(nmd);
      if (p < 0) begin
        d_len = 1;
      end else begin
        n = p / 4;
        if (p % 4 != 0) d_len++;
        if (n > 0) begin
          first = 1 + h + int'(nmd);
          avail = (tot_words > first) ? 2 * (tot_words - first) : 0;
          emit  = (n < avail) ? n : avail;
          ts_exp = (h == 1) ? words[1] : 64'd0;
          for (int k = 0; k < emit; k++) begin
            w = words[first + k / 2];
            item = (k % 2 == 1) ? w[63:32] : w[31:0];
            exp_q.push_back({(k == emit - 1), eob, h[0], seq, ts_exp, item});
          end
          if (n > avail) d_len++;
          else if (tot_words - first > (n + 1) / 2) d_len++;
        end
      end
    end
    rx0 = rx_count;
    for (int i = 0; i < tot_words; i++)
      send_word(words[i], (i == tot_words - 1));
    wait_drain("pkt");
    n_rx = rx_count - rx0;
    exp_drop += d_drop;
    exp_len  += d_len;
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [EXP_W-1:0] act;
    logic [EXP_W-1:0] e;
    if (!rst && m_item_tvalid && m_item_tready) begin
      act = {m_item_tlast, m_pkt_eob, m_pkt_has_ts, m_pkt_seqnum, m_pkt_ts, m_item_tdata};
      tests++;
      rx_count++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL item_extra actual=%h expected=none", act);
      end else begin
        e = exp_q.pop_front();
        if (act !== e) begin
          fails++;
          $display("FAIL item actual=%h expected=%h", act, e);
        end
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    int n_rx, d_drop, d_len, tbl_drop, tbl_len;
    int h, nmd, ni, need, tot, sel;
    logic [2:0]  pt;
    logic [15:0] len;
    logic [63:0] w0, w1, tsv;

    rst = 1'b1;
    s_chdr_tdata = '0;
    s_chdr_tlast = 1'b0;
    s_chdr_tvalid = 1'b0;

    vecs[0]  = '{3'd6, 1'b0, 5'd0, 16'd264, 33, 64'd0, 64, 0, 0};
    vecs[1]  = '{3'd7, 1'b0, 5'd0, 16'd28,  4,  64'h0123_4567_89AB_CDEF, 3, 0, 0};
    vecs[2]  = '{3'd6, 1'b1, 5'd2, 16'd40,  5,  64'd0, 4, 0, 0};
    vecs[3]  = '{3'd4, 1'b0, 5'd0, 16'd40,  5,  64'd0, 0, 1, 0};
    vecs[4]  = '{3'd6, 1'b0, 5'd0, 16'd72,  5,  64'd0, 8, 0, 1};
    vecs[5]  = '{3'd6, 1'b0, 5'd0, 16'd24,  5,  64'd0, 4, 0, 1};
    vecs[6]  = '{3'd6, 1'b0, 5'd0, 16'd8,   2,  64'd0, 0, 0, 0};
    vecs[7]  = '{3'd7, 1'b0, 5'd1, 16'd8,   3,  64'h55, 0, 0, 1};
    vecs[8]  = '{3'd6, 1'b0, 5'd0, 16'd18,  2,  64'd0, 2, 0, 1};
    vecs[9]  = '{3'd6, 1'b0, 5'd0, 16'd16,  1,  64'd0, 0, 0, 1};
    vecs[10] = '{3'd6, 1'b1, 5'd0, 16'd20,  3,  64'd0, 3, 0, 0};
    vecs[11] = '{3'd7, 1'b0, 5'd1, 16'd32,  4,  64'hDEAD_BEEF_0000_1111, 2, 0, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_s_tready", 64'(s_chdr_tready), 64'd0);
    check("rst_m_tvalid", 64'(m_item_tvalid), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("init_state", 64'(dbg_state), 64'(ST_HDR));
    check("init_s_tready", 64'(s_chdr_tready), 64'd1);
    check("init_pkt_ts", m_pkt_ts, 64'd0);
    check("init_sideband", {61'd0, m_pkt_eob, m_pkt_has_ts, |m_pkt_seqnum}, 64'd0);
    check_counters("init");
    @(posedge clk);
    #1;

    // table-driven packet shapes
    tbl_drop = 0;
    tbl_len  = 0;
    for (int i = 0; i < 12; i++) begin
      run_pkt(vecs[i].ptype, vecs[i].eob, vecs[i].nmd, vecs[i].len, vecs[i].words,
              vecs[i].ts, n_rx, d_drop, d_len);
      tbl_drop += vecs[i].exp_drop;
      tbl_len  += vecs[i].exp_len;
      check($sformatf("vec%0d_items", i), 64'(n_rx), 64'(vecs[i].exp_items));
      check($sformatf("vec%0d_cnt_drop", i), 64'(cnt_drop), CNT_EN ? 64'(tbl_drop) : 64'd0);
      check($sformatf("vec%0d_cnt_len", i), 64'(cnt_len_err), CNT_EN ? 64'(tbl_len) : 64'd0);
    end
    exp_drop = tbl_drop;
    exp_len  = tbl_len;

    // timestamped 3-item packet: final word is consumed on its LO item
    tsv = 64'h0123_4567_89AB_CDEF;
    w0 = {$urandom, $urandom};
    w1 = {$urandom, $urandom};
    exp_q.push_back({1'b0, 1'b0, 1'b1, 16'h1234, tsv, w0[31:0]});
    exp_q.push_back({1'b0, 1'b0, 1'b1, 16'h1234, tsv, w0[63:32]});
    exp_q.push_back({1'b1, 1'b0, 1'b1, 16'h1234, tsv, w1[31:0]});
    send_word(hdr_word(3'd7, 1'b0, 5'd0, 16'h1234, 16'd28), 1'b0);
    send_word(tsv, 1'b0);
    send_word(w0, 1'b0);
    s_chdr_tdata  = w1;
    s_chdr_tlast  = 1'b1;
    s_chdr_tvalid = 1'b1;
    @(negedge clk);
    check("ts3_lo_data", 64'(m_item_tdata), 64'(w1[31:0]));
    check("ts3_lo_tlast", 64'(m_item_tlast), 64'd1);
    check("ts3_lo_consume", 64'(s_chdr_tready), 64'd1);
    check("ts3_pkt_ts", m_pkt_ts, tsv);
    @(posedge clk);
    #1 s_chdr_tvalid = 1'b0;
    @(negedge clk);
    check("ts3_back_to_hdr", 64'(dbg_state), 64'(ST_HDR));
    wait_drain("ts3");
    check_counters("ts3");
    @(posedge clk);
    #1;

    // random packets with 25% stalls on both sides
    stall_en = 1'b1;
    for (int i = 0; i < 100; i++) begin
      sel = $urandom_range(0, 9);
      pt  = (sel == 0) ? 3'($urandom_range(0, 5)) : ((sel < 5) ? 3'd6 : 3'd7);
      h   = (pt == 3'd7) ? 1 : 0;
      nmd = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
      ni  = $urandom_range(1, 20);
      len = 16'(8 + 8 * h + 8 * nmd + 4 * ni);
      need = 1 + h + nmd + (ni + 1) / 2;
      sel = $urandom_range(0, 7);
      if (pt != 3'd6 && pt != 3'd7) tot = $urandom_range(1, 6);
      else if (sel == 0)            tot = $urandom_range(1, need - 1);
      else if (sel == 1)            tot = need + $urandom_range(1, 3);
      else                          tot = need;
      run_pkt(pt, 1'($urandom), 5'(nmd), len, tot, {$urandom, $urandom}, n_rx, d_drop, d_len);
      check_counters($sformatf("rnd%0d", i));
    end
    stall_en = 1'b0;
    @(posedge clk);
    #1;

    // reset in the middle of a 20-item payload
    w0 = {$urandom, $urandom};
    exp_q.push_back({1'b0, 1'b0, 1'b0, 16'h00AA, 64'd0, w0[31:0]});
    exp_q.push_back({1'b0, 1'b0, 1'b0, 16'h00AA, 64'd0, w0[63:32]});
    send_word(hdr_word(3'd6, 1'b0, 5'd0, 16'h00AA, 16'd88), 1'b0);
    send_word(w0, 1'b0);
    wait_drain("mid_rst_pre");
    s_chdr_tdata  = {$urandom, $urandom};
    s_chdr_tlast  = 1'b0;
    s_chdr_tvalid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_s_tready", 64'(s_chdr_tready), 64'd0);
    check("mid_rst_m_tvalid", 64'(m_item_tvalid), 64'd0);
    @(posedge clk);
    #1 s_chdr_tvalid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_drop = 0;
    exp_len  = 0;
    @(negedge clk);
    check("post_rst_state", 64'(dbg_state), 64'(ST_HDR));
    check("post_rst_seqnum", 64'(m_pkt_seqnum), 64'd0);
    check_counters("post_rst");
    @(posedge clk);
    #1;
    run_pkt(3'd6, 1'b1, 5'd0, 16'd24, 3, 64'd0, n_rx, d_drop, d_len);
    check("post_rst_items", 64'(n_rx), 64'd4);
    check_counters("post_rst_pkt");

    repeat (4) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/chdr_data_deframer.md
# chdr_data_deframer

Receive-side CHDR data deframer for RFNoC blocks: accepts a 64-bit AXIS-CHDR packet stream from the NoC shell, parses the header, skips the timestamp and metadata words, and emits the payload as a 32-bit item stream with per-packet sideband. It sits between the shell's data input port and user logic. It is the counterpart of the framer in the block controller BFM, which packs items into CHDR packets.

## Interface
- CHDR_W, 64, CHDR word width; only 64 is supported. Elaboration fails otherwise.
- ITEM_W, 32, item width; only 32 is supported.
- MTU, 10, log2 of the maximum packet length in CHDR words; sizes the word counter.

Ports:
- rfnoc_chdr_clk  in  1  sole clock
- rfnoc_chdr_rst  in  1  synchronous, active-high reset
- s_chdr_tdata  in  64  CHDR input word
- s_chdr_tlast  in  1  last word of packet
- s_chdr_tvalid  in  1  input valid
- s_chdr_tready  out  1  input ready
- m_item_tdata  out  32  payload item
- m_item_tlast  out  1  last item of packet
- m_item_tvalid  out  1  item valid
- m_item_tready  in  1  item ready
- m_pkt_eob  out  1  EOB flag of the current packet
- m_pkt_has_ts  out  1  packet carried a timestamp
- m_pkt_ts  out  64  timestamp; 0 if none
- m_pkt_seqnum  out  16  header SeqNum
- cnt_drop  out  16  packets dropped
- cnt_len_err  out  16  length/tlast mismatches

## Operation
- Header fields:
  - [55:53] PktType: 6 = data, 7 = data with timestamp.
  - [52:48] NumMData, in 64-bit words.
  - [47:32] SeqNum.
  - [31:16] Length, in bytes, covering the whole packet.
  - [57] EOB.
- Payload bytes: P = Length − 8 − 8·has_ts − 8·NumMData. Item count: N = P>>2.
- FSM states: HDR, TS, MDATA, PYLD_LO, PYLD_HI, DROP.
- HDR: accept one word and latch all sideband fields.
  - Type 7 → TS.
  - Type 6 with NumMData > 0 → MDATA.
  - Type 6 otherwise → PYLD_LO.
  - Any other type → DROP, and cnt_drop increments.
  - P < 0 → DROP, and cnt_len_err increments.
  - N = 0 → DROP, with no counter change.
  - If the header word itself has tlast, return to HDR.
- TS: latch the word into m_pkt_ts. In MDATA, discard NumMData words.
- PYLD_LO presents tdata[31:0]. PYLD_HI presents tdata[63:32]. Items are taken lower half first.
- A word is consumed (s_chdr_tready = 1) when:
  - its HI item is accepted, or
  - its LO item is accepted and that item is the final item.
- m_item_tlast is asserted on item N. The FSM then goes to DROP to absorb any remaining words up to tlast.
  - If remaining words exist, cnt_len_err increments.
  - If the item-N word carries tlast, go straight to HDR.
- If s_chdr_tlast arrives before item N:
  - force m_item_tlast on the last item present in that word;
  - increment cnt_len_err;
  - go to HDR.
- P not a multiple of 4: the residual bytes are ignored and cnt_len_err increments.
- DROP: s_chdr_tready = 1. Exit to HDR on tlast.
- Counters saturate at 0xFFFF.

## Timing
- Item path is combinational from s_chdr to m_item (zero cycles). m_item_tvalid = s_chdr_tvalid in PYLD states.
- Throughput:
  - one item per clock while m_item_tready = 1;
  - one header, timestamp, or metadata word per clock.
- Sideband registers update on header/timestamp acceptance. They hold stable from the first item through m_item_tlast.
- AXIS rules: tvalid never depends on tready. Data is held while valid && !ready.
- Reset values:
  - FSM in HDR;
  - s_chdr_tready = 0 during reset and 1 in HDR;
  - all m_* outputs 0;
  - counters 0.
- Reset mid-packet: the FSM returns to HDR. The next word is treated as a header, so the upstream logic must be reset or flushed together with this block.

## Configuration
- CHDR_DEFRAMER_ERR_CNT_EN:
  - Defined: cnt_drop and cnt_len_err are implemented.
  - Undefined: both outputs are tied to 0 and no counter flops exist.
  - Parsing, dropping and truncation behave identically in both cases.

## Structure
- chdr_deframer_pkg holds:
  - PKT_TYPE_DATA = 3'd6 and PKT_TYPE_DATA_TS = 3'd7;
  - header field bit-offset constants;
  - the state enum typedef;
  - a chdr_hdr_t packed struct.
- Sub-module chdr_hdr_decode: combinational header unpack plus P/N computation, reusable by a future framer check.

## Test plan
- Type 6 header, Length = 8+64·4, random items → 64 items out in order (LO then HI); tlast on item 64; has_ts = 0.
- Type 7 header, ts = 0x0123_4567_89AB_CDEF, 3 items, Length = 28 → 3 items; second word consumed after LO only; m_pkt_ts matches.
- NumMData = 2 plus 4 items → metadata not emitted; exactly 4 items; EOB = 1 propagated.
- Type 4 (control) packet of 5 words → no items; cnt_drop = 1; next data packet correct.
- Length claims 16 items, tlast after 8 items → tlast on item 8; cnt_len_err = 1. Extra 2 words beyond Length → discarded; cnt_len_err increments.
- 25% random m_item_tready/s_chdr_tvalid stalls over 100 packets, plus reset asserted mid-payload → scoreboard matches; post-reset packet parsed from HDR.
